// File: rtl/mem_pkg.sv
// Shared constants and controller state type for the memory read-back checker.
package mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/mem_check_if.sv
// Memory-port bundle shared between the checker (master) and the memory mux (slave).
interface mem_check_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
);
  logic [ADDR_W-1:0] address;
  logic              wren;
  logic [DATA_W-1:0] q;

  modport master (output address, output wren, input q);
  modport slave  (input address, input wren, output q);
endinterface

// File: rtl/rd_pipe.sv
// Delay line that tags each issued address with a valid bit and re-presents
// it exactly RD_LAT cycles later, aligned with the memory's read data.
module rd_pipe #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy
);
  logic              vld [RD_LAT];
  logic [ADDR_W-1:0] adr [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        vld[i] <= 1'b0;
        adr[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      adr[0] <= in_addr;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_addr  = adr[RD_LAT-1];

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < RD_LAT; i++) busy = busy | vld[i];
  end
endmodule

// File: rtl/mem_check.sv
// Sequential read-back checker: scans every word, compares it with its own
// address, and reports pass, error count, first bad address and a checksum.
module mem_check #(
  parameter int DEPTH  = mem_pkg::DEPTH,
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              finish,
  mem_check_if.master       mem,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_bad,
  output logic [15:0]       checksum
);
  import mem_pkg::*;

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic              issue;
  logic              chk_valid;
  logic [ADDR_W-1:0] chk_addr;
  logic              pipe_busy;
  logic [DATA_W-1:0] exp_word;
  logic              miss;

  rd_pipe #(
    .RD_LAT(RD_LAT),
    .ADDR_W(ADDR_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_addr   (mem.address),
    .out_valid (chk_valid),
    .out_addr  (chk_addr),
    .busy      (pipe_busy)
  );

  assign exp_word = DATA_W'(chk_addr);
  assign miss     = chk_valid && (mem.q != exp_word);

  // The issue flag travels with the registered address so the delay line sees
  // exactly the address the memory is being driven with in that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem.address <= '0;
      mem.wren    <= 1'b0;
      finish      <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      first_bad   <= '0;
      checksum    <= '0;
      cnt         <= '0;
      issue       <= 1'b0;
    end else begin
      mem.wren <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SCAN;
            mem.address <= '0;
            cnt         <= (ADDR_W+1)'(1);
            issue       <= 1'b1;
            err_count   <= '0;
            first_bad   <= '0;
            checksum    <= '0;
            pass        <= 1'b0;
          end
        end
        SCAN: begin
          if (cnt == LAST) begin
            state <= DRAIN;
            issue <= 1'b0;
          end else begin
            mem.address <= cnt[ADDR_W-1:0];
            cnt         <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          // Final accumulator update has landed once nothing is left in flight.
          if (!pipe_busy) begin
            state  <= DONE;
            finish <= 1'b1;
            pass   <= (err_count == '0);
          end
        end
        DONE: begin
          if (!start) begin
            state  <= IDLE;
            finish <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (chk_valid) begin
        checksum <= checksum + 16'(mem.q);
        if (miss) begin
          if (err_count == '0) first_bad <= chk_addr;
          if (err_count != LAST) err_count <= err_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_check.sv
// Scoreboard bench: two checkers (read latency 1 and 2) scan the same memory
// image; expected results come from a direct sum/compare over that image.
module tb_mem_check;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int N  = 256;

  typedef struct {
    logic          pass;
    logic [AW:0]   err;
    logic [AW-1:0] first;
    logic [15:0]   sum;
    int            c0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;

  logic          fin  [2];
  logic          ps   [2];
  logic [AW:0]   ec   [2];
  logic [AW-1:0] fb   [2];
  logic [15:0]   cs   [2];
  logic [AW-1:0] addr_a [2];
  logic          wren_a [2];

  logic [DW-1:0] mem [N];
  exp_t sb0 [$];
  exp_t sb1 [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt [2];
  int last_width [2];
  int wren_seen = 0;

  mem_check_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_check_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  mem_check #(.DEPTH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .finish(fin[0]), .mem(bus0),
    .pass(ps[0]), .err_count(ec[0]), .first_bad(fb[0]), .checksum(cs[0])
  );
  mem_check #(.DEPTH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .finish(fin[1]), .mem(bus1),
    .pass(ps[1]), .err_count(ec[1]), .first_bad(fb[1]), .checksum(cs[1])
  );

  assign addr_a[0] = bus0.address;
  assign addr_a[1] = bus1.address;
  assign wren_a[0] = bus0.wren;
  assign wren_a[1] = bus1.wren;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    int err = 0;
    int first = 0;
    int sum = 0;
    for (int i = 0; i < N; i++) begin
      sum = sum + int'(mem[i]);
      if (int'(mem[i]) != (i % (1 << DW))) begin
        if (err == 0) first = i;
        err++;
      end
    end
    e.pass  = (err == 0);
    e.err   = (AW+1)'(err);
    e.first = AW'(first);
    e.sum   = 16'(sum % 65536);
    e.c0    = 0;
    return e;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t qpeek(input int d);
    return (d == 0) ? sb0[0] : sb1[0];
  endfunction

  function automatic exp_t qpop(input int d);
    if (d == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  // Memory model: q in cycle m holds the word addressed RD_LAT cycles earlier.
  initial begin
    logic [AW-1:0] h [2][3];
    for (int d = 0; d < 2; d++)
      for (int j = 0; j < 3; j++) h[d][j] = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        h[d][2] = h[d][1];
        h[d][1] = h[d][0];
        h[d][0] = addr_a[d];
      end
      bus0.q = mem[h[0][1]];
      bus1.q = mem[h[1][2]];
    end
  end

  // Monitor: checks address sequence during a scan, pops and compares on finish.
  initial begin
    logic pf [2];
    int   wid [2];
    int   bad_a [2];
    exp_t e;
    int   k;
    for (int d = 0; d < 2; d++) begin
      pf[d] = 1'b0; wid[d] = 0; bad_a[d] = 0; done_cnt[d] = 0; last_width[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (wren_a[d]) wren_seen++;
        if (!rst) begin
          pf[d] = 1'b0; wid[d] = 0; bad_a[d] = 0;
        end else begin
          if (qsize(d) > 0 && !fin[d]) begin
            e = qpeek(d);
            k = cyc - e.c0;
            if (k >= 0 && k <= N + d + 1)
              if (int'(addr_a[d]) != ((k < N) ? k : N - 1)) bad_a[d]++;
          end
          if (fin[d] && !pf[d]) begin
            if (qsize(d) == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_finish dut%0d: got finish=1, expected no finish", d);
            end else begin
              e = qpop(d);
              chk($sformatf("latency dut%0d", d), cyc - e.c0, N + d + 2);
              chk($sformatf("pass dut%0d", d), ps[d], e.pass);
              chk($sformatf("err_count dut%0d", d), ec[d], e.err);
              chk($sformatf("first_bad dut%0d", d), fb[d], e.first);
              chk($sformatf("checksum dut%0d", d), cs[d], e.sum);
              chk($sformatf("addr_seq_errors dut%0d", d), bad_a[d], 0);
              done_cnt[d]++;
            end
            bad_a[d] = 0;
          end
          if (fin[d]) wid[d]++;
          else if (pf[d]) begin
            last_width[d] = wid[d];
            wid[d] = 0;
          end
          pf[d] = fin[d];
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_done(input int t0, input int t1);
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt[0] >= t0 && done_cnt[1] >= t1) return;
      tick(1);
    end
    tests++; fails++;
    $display("FAIL finish_timeout: got %0d/%0d scans done, expected %0d/%0d",
             done_cnt[0], done_cnt[1], t0, t1);
  endtask

  task automatic run_scan(input int drop_at, output exp_t e);
    int t0;
    int t1;
    e = model();
    e.c0 = cyc + 1;
    sb0.push_back(e);
    sb1.push_back(e);
    t0 = done_cnt[0] + 1;
    t1 = done_cnt[1] + 1;
    last_width[0] = -1;
    last_width[1] = -1;
    start = 1'b1;
    if (drop_at >= 0) begin
      tick(1);
      for (int i = 0; i < 400 && int'(addr_a[0]) != drop_at; i++) tick(1);
      chk("drop_point_addr", addr_a[0], drop_at);
      start = 1'b0;
    end
    wait_done(t0, t1);
  endtask

  task automatic after_scan(input logic held, input exp_t e);
    if (held) begin
      tick(2);
      chk("hold_finish dut0", fin[0], 1);
      chk("hold_pass dut0", ps[0], e.pass);
      chk("hold_checksum dut0", cs[0], e.sum);
      start = 1'b0;
      tick(1);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("finish_drop dut%0d", d), fin[d], 0);
        chk($sformatf("retain_checksum dut%0d", d), cs[d], e.sum);
        chk($sformatf("retain_err dut%0d", d), ec[d], e.err);
      end
    end else begin
      tick(1);
      chk("finish_width dut0", last_width[0], 1);
      chk("finish_width dut1", last_width[1], 1);
    end
  endtask

  initial begin
    exp_t e;
    int   drop;
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    tick(2);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_finish dut%0d", d), fin[d], 0);
      chk($sformatf("rst_pass dut%0d", d), ps[d], 0);
      chk($sformatf("rst_err dut%0d", d), ec[d], 0);
      chk($sformatf("rst_first dut%0d", d), fb[d], 0);
      chk($sformatf("rst_sum dut%0d", d), cs[d], 0);
      chk($sformatf("rst_addr dut%0d", d), addr_a[d], 0);
    end
    rst = 1'b1;
    tick(3);
    chk("idle_no_start dut0", fin[0], 0);
    chk("idle_addr dut0", addr_a[0], 0);

    run_scan(-1, e);
    chk("identity_sum dut0", cs[0], 16'h7F80);
    chk("identity_pass dut0", ps[0], 1);
    after_scan(1'b1, e);

    mem[5] = 8'hFF;
    mem[200] = 8'hFF;
    run_scan(-1, e);
    chk("corrupt_err dut0", ec[0], 2);
    chk("corrupt_first dut0", fb[0], 5);
    chk("corrupt_sum dut0", cs[0], 16'h80B1);
    after_scan(1'b1, e);

    for (int i = 0; i < N; i++) mem[i] = 8'hFF;
    run_scan(-1, e);
    chk("allff_err dut1", ec[1], 255);
    chk("allff_first dut1", fb[1], 0);
    chk("allff_sum dut1", cs[1], 16'hFF00);
    after_scan(1'b1, e);

    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    start = 1'b1;
    tick(1);
    for (int i = 0; i < 400 && addr_a[0] != 8'd100; i++) tick(1);
    chk("abort_point_addr", addr_a[0], 100);
    #1 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort_finish dut%0d", d), fin[d], 0);
      chk($sformatf("abort_sum dut%0d", d), cs[d], 0);
      chk($sformatf("abort_addr dut%0d", d), addr_a[d], 0);
      chk($sformatf("abort_err dut%0d", d), ec[d], 0);
    end
    start = 1'b0;
    sb0.delete();
    sb1.delete();
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("post_abort_idle dut1", addr_a[1], 0);
    run_scan(-1, e);
    chk("post_abort_pass dut0", ps[0], 1);
    chk("post_abort_pass dut1", ps[1], 1);
    after_scan(1'b1, e);

    mem[77] = 8'h00;
    run_scan(50, e);
    after_scan(1'b0, e);
    run_scan(-1, e);
    after_scan(1'b1, e);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        mem[i] = ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'(i);
      if (r == 2) for (int i = 0; i < N; i++) mem[i] = DW'(i);
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      run_scan(drop, e);
      after_scan(drop < 0, e);
    end

    chk("wren_never_high", wren_seen, 0);
    chk("scoreboard_empty", sb0.size() + sb1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
